ru_fault_scheduler: RTL and testbench
=====================================

# ru_fault_scheduler

Allocates the pool of redundant recompute units (RUs) to the faulty PEs of an output-stationary systolic array. Works from the self-test fault map (`stw_result_mat`) and handles any fault count up to ROWS*COLS, so the count may exceed NUM_RU. It hands out one faulty-PE coordinate per cycle to a free RU and frees the RU on its completion pulse. Once every fault is recomputed it signals done. It sits between BIST result capture and the per-RU input-feed controller, which starts a recompute on each `ru_start` pulse.

## Interface
- ROWS, 4: array rows; power of two, at least 2.
- COLS, 4: array columns; power of two, at least 2.
- NUM_RU, 4: number of redundant units; at least 1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; active-low, asynchronous assert.
- start  in  1  one-cycle request to schedule the current fault map; ignored while `busy`.
- stw_result_mat  in  ROWS*COLS  fault map; bit r*COLS+c is PE(r,c); 1 means healthy, 0 means faulty.
- ru_done  in  NUM_RU  one-cycle pulse per RU marking its recompute result as consumed.
- ru_en  out  NUM_RU  RU i currently holds an assignment.
- ru_start  out  NUM_RU  one-cycle pulse in the cycle an assignment to RU i first becomes visible.
- ru_row_mapping  out  clog2(ROWS)*NUM_RU  row of the PE assigned to RU i, in slice i.
- ru_col_mapping  out  clog2(COLS)*NUM_RU  column of the PE assigned to RU i, in slice i.
- fault_count  out  clog2(ROWS*COLS+1)  number of faults in the latched map.
- busy  out  1  high from the load edge until the return to IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE: if start, latch the pending mask and go to DISPATCH.
  - DISPATCH: assign PEs and release RUs; when pending==0 and ru_en==0, go to DONE.
  - DONE: go to IDLE.
- Pending mask: loaded as ~stw_result_mat, reordered column-major. Pending index p = c*ROWS+r, so r = p mod ROWS and c = p / ROWS; both are bit slices because ROWS is a power of two.
- `fault_count` is the popcount of the pending mask at load. It holds until the next load.
- Assignment happens in DISPATCH, at most one per cycle. Take the lowest pending p and the lowest i with ru_en[i]==0 as sampled at that edge. Then:
  - set ru_en[i] and pulse ru_start[i];
  - write the row and column slices for RU i;
  - clear pending bit p.
- Release: when ru_done[i] and ru_en[i] are both high, clear ru_en[i]. Ignore ru_done[i] while ru_en[i]==0.
- A released RU is not eligible for reassignment until the following edge. The done and assign for the same RU in one cycle therefore never collide.
- Mapping slices hold their last value after release.
- `start` while busy is ignored, and the latched map is unaffected. Changes to `stw_result_mat` after load are ignored.
- Reset: all outputs, the pending mask, the mapping slices and `fault_count` go to 0, and the state goes to IDLE. Reset mid-operation abandons all assignments with no done pulse.

## Timing
- With start sampled at edge k: busy=1 and the state is DISPATCH after k.
- The first assignment (ru_en, ru_start, mappings) is visible after k+1. Each further assignment follows one edge later while a free RU exists.
- Each ru_start pulse lasts exactly one cycle.
- Zero faults: done=1 after k+1, then done=0 and busy=0 after k+2.
- Completion: if the last ru_done is sampled at edge m, ru_en clears after m, done=1 after m+1, and busy=0 / IDLE after m+2.
- No combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding (IDLE, DISPATCH, DONE);
  - a function `index_width(n) = clog2(n)`.
- One sub-module, `ru_lowest_set`: parameterised-width priority encoder returning a valid flag and the lowest set index. It is instantiated twice: on the pending mask and on ~ru_en.
- Counters and mapping registers are local to this block.

## Test plan
- Two faults: stw=16'hBFEF, i.e. faulty PE(1,0) at bit 4 and PE(3,2) at bit 14. Then fault_count=2, RU0 gets row1/col0 at k+1, RU1 gets row3/col2 at k+2, and ru_start pulses once each.
- Zero faults: stw=16'hFFFF with start → fault_count=0, no ru_start, done pulse after k+1.
- Six faults in column 0 and column 1 (rows 0–2 each) with NUM_RU=4:
  - RU0–RU3 get (0,0), (1,0), (2,0), (0,1) on consecutive cycles;
  - ru_done[2] → RU2 gets (1,1) one cycle after release;
  - done comes 2 edges after the last ru_done.
- Stray and overlapping events:
  - ru_done[3] while RU3 is idle → no state change;
  - start pulsed mid-DISPATCH with a different map → ignored, and fault_count unchanged.
- Reset asserted mid-DISPATCH → all outputs 0 asynchronously; after release, a new start schedules from scratch.

Source files
------------

// File: rtl/ru_fault_scheduler_pkg.sv
// Shared definitions for the redundant-unit fault scheduler:
// the FSM state encoding and the index width helper.
package ru_fault_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  function automatic int index_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ru_fault_scheduler_if.sv
// Bundle of the scheduler's control, fault-map and per-RU signals.
// Handshake: start and ru_done are single-cycle pulses with no back-pressure;
// start is taken only in IDLE, ru_done[i] only while ru_en[i] is high.
interface ru_fault_scheduler_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4
);
  import ru_fault_scheduler_pkg::*;

  localparam int RW = index_width(ROWS);
  localparam int CW = index_width(COLS);
  localparam int FW = index_width(ROWS * COLS + 1);

  logic                   start;
  logic [ROWS*COLS-1:0]   stw_result_mat;
  logic [NUM_RU-1:0]      ru_done;
  logic [NUM_RU-1:0]      ru_en;
  logic [NUM_RU-1:0]      ru_start;
  logic [RW*NUM_RU-1:0]   ru_row_mapping;
  logic [CW*NUM_RU-1:0]   ru_col_mapping;
  logic [FW-1:0]          fault_count;
  logic                   busy;
  logic                   done;
  state_t                 state;

  modport master (
    output start, stw_result_mat, ru_done,
    input  ru_en, ru_start, ru_row_mapping, ru_col_mapping,
    input  fault_count, busy, done, state
  );

  modport slave (
    input  start, stw_result_mat, ru_done,
    output ru_en, ru_start, ru_row_mapping, ru_col_mapping,
    output fault_count, busy, done, state
  );

endinterface

// File: rtl/ru_lowest_set.sv
// Priority encoder: reports whether any bit of vec is set and the index
// of the lowest set bit (0 when none is set).
module ru_lowest_set
  import ru_fault_scheduler_pkg::*;
#(
  parameter int W  = 4,
  parameter int IW = (W > 1) ? index_width(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |vec;
    idx   = '0;
    // Descending scan so the last hit, the lowest index, wins.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/ru_fault_scheduler.sv
// Hands faulty-PE coordinates from the self-test map to free redundant
// recompute units, one per cycle, and pulses done once all are consumed.
module ru_fault_scheduler
  import ru_fault_scheduler_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ru_fault_scheduler_if.slave  bus
);

  localparam int RW = index_width(ROWS);
  localparam int CW = index_width(COLS);
  localparam int NP = ROWS * COLS;
  localparam int PW = RW + CW;
  localparam int FW = index_width(NP + 1);
  localparam int UW = (NUM_RU > 1) ? index_width(NUM_RU) : 1;

  state_t               state, state_next;
  logic [NP-1:0]        pending, pend_load;
  logic [FW-1:0]        fault_count, load_count;
  logic [NUM_RU-1:0]    ru_en, ru_start, release_mask, assign_mask;
  logic [RW*NUM_RU-1:0] row_map;
  logic [CW*NUM_RU-1:0] col_map;
  logic                 pend_valid, free_valid, do_assign;
  logic [PW-1:0]        pend_idx;
  logic [UW-1:0]        free_idx;

  ru_lowest_set #(.W(NP), .IW(PW)) u_pend_enc (
    .vec   (pending),
    .valid (pend_valid),
    .idx   (pend_idx)
  );

  ru_lowest_set #(.W(NUM_RU), .IW(UW)) u_free_enc (
    .vec   (~ru_en),
    .valid (free_valid),
    .idx   (free_idx)
  );

  // Column-major reorder: pending index p = c*ROWS + r, so the low RW bits
  // of p are the row and the high CW bits the column.
  always_comb begin
    pend_load  = '0;
    load_count = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        pend_load[c*ROWS + r] = ~bus.stw_result_mat[r*COLS + c];
      end
    end
    for (int p = 0; p < NP; p++) begin
      load_count = load_count + FW'(pend_load[p]);
    end
  end

  // Free RUs come from the registered ru_en, so a unit released this edge
  // only becomes eligible on the next one.
  always_comb begin
    do_assign    = (state == ST_DISPATCH) && pend_valid && free_valid;
    release_mask = bus.ru_done & ru_en;
    assign_mask  = '0;
    for (int i = 0; i < NUM_RU; i++) begin
      if (do_assign && (free_idx == UW'(i))) assign_mask[i] = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (bus.start) state_next = ST_DISPATCH;
      ST_DISPATCH: if ((pending == '0) && (ru_en == '0)) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending     <= '0;
      fault_count <= '0;
      ru_en       <= '0;
      ru_start    <= '0;
      row_map     <= '0;
      col_map     <= '0;
    end else begin
      ru_start <= assign_mask;
      ru_en    <= (ru_en & ~release_mask) | assign_mask;
      if ((state == ST_IDLE) && bus.start) begin
        pending     <= pend_load;
        fault_count <= load_count;
      end else if (do_assign) begin
        pending[pend_idx] <= 1'b0;
      end
      for (int i = 0; i < NUM_RU; i++) begin
        if (assign_mask[i]) begin
          row_map[i*RW +: RW] <= pend_idx[RW-1:0];
          col_map[i*CW +: CW] <= pend_idx[PW-1:RW];
        end
      end
    end
  end

  assign bus.ru_en          = ru_en;
  assign bus.ru_start       = ru_start;
  assign bus.ru_row_mapping = row_map;
  assign bus.ru_col_mapping = col_map;
  assign bus.fault_count    = fault_count;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = (state == ST_DONE);
  assign bus.state          = state;

endmodule

// File: tb/tb_ru_fault_scheduler.sv
// Bench for ru_fault_scheduler on a 4x4 array with four RUs; assignments
// are scored against an expected queue built from a fault-order model.
module tb_ru_fault_scheduler;
  import ru_fault_scheduler_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [5:0] exp_q[$];
  logic [3:0] fault_q[$];

  ru_fault_scheduler_if #(.ROWS(4), .COLS(4), .NUM_RU(4)) bus ();

  ru_fault_scheduler #(.ROWS(4), .COLS(4), .NUM_RU(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  // model: faulty PEs in column-major order as {row, col}
  task automatic build_faults(input logic [15:0] map);
    logic [1:0] rr, cc;
    fault_q.delete();
    for (int p = 0; p < 16; p++) begin
      rr = 2'(p % 4);
      cc = 2'(p / 4);
      if (!map[rr*4 + cc]) fault_q.push_back({rr, cc});
    end
  endtask

  task automatic expect_next(input logic [1:0] ru);
    exp_q.push_back({ru, fault_q.pop_front()});
  endtask

  // driver tasks; all begin and end at a falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [15:0] map);
    bus.stw_result_mat = map;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_done(input logic [3:0] mask);
    bus.ru_done = mask;
    tick();
    bus.ru_done = 4'b0000;
  endtask

  // scoreboard: every ru_start bit pops one expected assignment
  always @(negedge clk) begin
    logic [5:0] got, exp;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ru_start[i]) begin
          got = {2'(i), bus.ru_row_mapping[i*2 +: 2], bus.ru_col_mapping[i*2 +: 2]};
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_assign: got ru=%0d row=%0d col=%0d, required none", got[5:4], got[3:2], got[1:0]);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL assign: got ru=%0d row=%0d col=%0d, required ru=%0d row=%0d col=%0d",
                       got[5:4], got[3:2], got[1:0], exp[5:4], exp[3:2], exp[1:0]);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (bus.ru_en !== 4'b0) begin n_fail++; $display("FAIL rst_ru_en: got %b, required 0000", bus.ru_en); end
    n_tests++; if (bus.ru_start !== 4'b0) begin n_fail++; $display("FAIL rst_ru_start: got %b, required 0000", bus.ru_start); end
    n_tests++; if (bus.ru_row_mapping !== 8'h0) begin n_fail++; $display("FAIL rst_row_map: got %h, required 00", bus.ru_row_mapping); end
    n_tests++; if (bus.ru_col_mapping !== 8'h0) begin n_fail++; $display("FAIL rst_col_map: got %h, required 00", bus.ru_col_mapping); end
    n_tests++; if (bus.fault_count !== 5'd0) begin n_fail++; $display("FAIL rst_fault_count: got %0d, required 0", bus.fault_count); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", bus.done); end
    n_tests++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d, required IDLE", bus.state); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_two_faults();
    build_faults(16'hBFEF);
    expect_next(2'd0);
    expect_next(2'd1);
    pulse_start(16'hBFEF);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL two_busy: got %b, required 1", bus.busy); end
    n_tests++; if (bus.state !== ST_DISPATCH) begin n_fail++; $display("FAIL two_state: got %0d, required DISPATCH", bus.state); end
    n_tests++; if (bus.fault_count !== 5'd2) begin n_fail++; $display("FAIL two_count: got %0d, required 2", bus.fault_count); end
    n_tests++; if (bus.ru_en !== 4'b0000) begin n_fail++; $display("FAIL two_en_k: got %b, required 0000", bus.ru_en); end
    tick();
    n_tests++; if (bus.ru_en !== 4'b0001) begin n_fail++; $display("FAIL two_en_k1: got %b, required 0001", bus.ru_en); end
    tick();
    n_tests++; if (bus.ru_en !== 4'b0011) begin n_fail++; $display("FAIL two_en_k2: got %b, required 0011", bus.ru_en); end
    n_tests++; if (bus.ru_start !== 4'b0010) begin n_fail++; $display("FAIL two_start_k2: got %b, required 0010", bus.ru_start); end
    tick();
    n_tests++; if (bus.ru_start !== 4'b0000) begin n_fail++; $display("FAIL two_start_k3: got %b, required 0000", bus.ru_start); end
    pulse_done(4'b0011);
    n_tests++; if (bus.ru_en !== 4'b0000) begin n_fail++; $display("FAIL two_en_rel: got %b, required 0000", bus.ru_en); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL two_done_m: got %b, required 0", bus.done); end
    n_tests++; if (bus.ru_row_mapping[3:2] !== 2'd3) begin n_fail++; $display("FAIL two_row_hold: got %0d, required 3", bus.ru_row_mapping[3:2]); end
    tick();
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL two_done_m1: got %b, required 1", bus.done); end
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL two_done_m2: got %b, required 0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL two_busy_m2: got %b, required 0", bus.busy); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL two_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_zero_faults();
    pulse_start(16'hFFFF);
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b, required 1", bus.busy); end
    n_tests++; if (bus.fault_count !== 5'd0) begin n_fail++; $display("FAIL zero_count: got %0d, required 0", bus.fault_count); end
    tick();
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL zero_done_k1: got %b, required 1", bus.done); end
    n_tests++; if (bus.ru_en !== 4'b0000) begin n_fail++; $display("FAIL zero_en: got %b, required 0000", bus.ru_en); end
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_done_k2: got %b, required 0", bus.done); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_k2: got %b, required 0", bus.busy); end
  endtask

  task automatic test_six_faults();
    build_faults(16'hFCCC);
    for (int i = 0; i < 4; i++) expect_next(2'(i));
    pulse_start(16'hFCCC);
    n_tests++; if (bus.fault_count !== 5'd6) begin n_fail++; $display("FAIL six_count: got %0d, required 6", bus.fault_count); end
    tick(); tick(); tick(); tick();
    n_tests++; if (bus.ru_en !== 4'b1111) begin n_fail++; $display("FAIL six_en_full: got %b, required 1111", bus.ru_en); end
    tick();
    n_tests++; if (bus.ru_start !== 4'b0000) begin n_fail++; $display("FAIL six_no_free: got %b, required 0000", bus.ru_start); end
    expect_next(2'd2);
    pulse_done(4'b0100);
    n_tests++; if (bus.ru_en !== 4'b1011) begin n_fail++; $display("FAIL six_rel2: got %b, required 1011", bus.ru_en); end
    tick();
    n_tests++; if (bus.ru_en !== 4'b1111) begin n_fail++; $display("FAIL six_reassign2: got %b, required 1111", bus.ru_en); end
    expect_next(2'd0);
    pulse_done(4'b0001);
    tick();
    n_tests++; if (bus.ru_en !== 4'b1111) begin n_fail++; $display("FAIL six_reassign0: got %b, required 1111", bus.ru_en); end
    pulse_done(4'b1000);
    n_tests++; if (bus.ru_en !== 4'b0111) begin n_fail++; $display("FAIL six_rel3: got %b, required 0111", bus.ru_en); end
    n_tests++; if ({bus.ru_row_mapping[7:6], bus.ru_col_mapping[7:6]} !== 4'b0001) begin n_fail++; $display("FAIL six_map_hold: got %b, required 0001", {bus.ru_row_mapping[7:6], bus.ru_col_mapping[7:6]}); end
    // stray ru_done on idle RU3, then a start with a different map
    pulse_done(4'b1000);
    n_tests++; if (bus.ru_en !== 4'b0111) begin n_fail++; $display("FAIL six_stray: got %b, required 0111", bus.ru_en); end
    pulse_start(16'h0000);
    tick();
    n_tests++; if (bus.fault_count !== 5'd6) begin n_fail++; $display("FAIL six_restart_count: got %0d, required 6", bus.fault_count); end
    n_tests++; if (bus.state !== ST_DISPATCH) begin n_fail++; $display("FAIL six_restart_state: got %0d, required DISPATCH", bus.state); end
    n_tests++; if (bus.ru_en !== 4'b0111) begin n_fail++; $display("FAIL six_restart_en: got %b, required 0111", bus.ru_en); end
    pulse_done(4'b0111);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL six_done_m: got %b, required 0", bus.done); end
    tick();
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL six_done_m1: got %b, required 1", bus.done); end
    tick();
    n_tests++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL six_idle_m2: got %0d, required IDLE", bus.state); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL six_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    build_faults(16'h0000);
    expect_next(2'd0);
    expect_next(2'd1);
    pulse_start(16'h0000);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    n_tests++; if (bus.ru_en !== 4'b0) begin n_fail++; $display("FAIL mid_ru_en: got %b, required 0000", bus.ru_en); end
    n_tests++; if (bus.ru_start !== 4'b0) begin n_fail++; $display("FAIL mid_ru_start: got %b, required 0000", bus.ru_start); end
    n_tests++; if ({bus.ru_row_mapping, bus.ru_col_mapping} !== 16'h0) begin n_fail++; $display("FAIL mid_maps: got %h, required 0000", {bus.ru_row_mapping, bus.ru_col_mapping}); end
    n_tests++; if (bus.fault_count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d, required 0", bus.fault_count); end
    n_tests++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL mid_busy_done: got %b, required 00", {bus.busy, bus.done}); end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done: got %b, required 0", bus.done); end
    build_faults(16'hBFEF);
    expect_next(2'd0);
    expect_next(2'd1);
    pulse_start(16'hBFEF);
    n_tests++; if (bus.fault_count !== 5'd2) begin n_fail++; $display("FAIL mid_new_count: got %0d, required 2", bus.fault_count); end
    tick(); tick();
    n_tests++; if (bus.ru_en !== 4'b0011) begin n_fail++; $display("FAIL mid_new_en: got %b, required 0011", bus.ru_en); end
    pulse_done(4'b0011);
    tick(); tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_new_busy: got %b, required 0", bus.busy); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL mid_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    n_tests            = 0;
    n_fail             = 0;
    rst                = 1'b0;
    bus.start          = 1'b0;
    bus.ru_done        = 4'b0000;
    bus.stw_result_mat = 16'hFFFF;
    test_reset();
    test_two_faults();
    test_zero_faults();
    test_six_faults();
    test_reset_mid();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
